ring_cadence_ctrl: RTL

RING_CADENCE_CTRL -- requirements
Module: ring_cadence_ctrl

---
 rtl/ring_cadence_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ring_cadence_ctrl.sv
// Ring cadence controller: bursts of ON/OFF alerting while a call is presented,
// with an alert mode selector and a saturating missed-call counter.
module ring_cadence_ctrl #(
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 16,
    parameter int MAX_BURSTS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       incoming_call,
    input  logic       answer,
    input  logic       mode_btn,
    input  logic       clr_missed,
    output logic       ring,
    output logic       vibrate_mode,
    output logic [1:0] mode,
    output logic       missed_call,
    output logic [3:0] missed_count
);

    localparam int CNT_MAX = ((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int BW      = $clog2(MAX_BURSTS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ON       = 3'd1;
    localparam logic [2:0] S_OFF      = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_ANSWERED = 3'd4;

    localparam logic [1:0] M_NORMAL  = 2'd0;
    localparam logic [1:0] M_VIBRATE = 2'd1;
    localparam logic [1:0] M_SILENT  = 2'd2;

    logic [2:0]    state, state_next;
    logic [CW-1:0] cycle_cnt, cycle_next;
    logic [BW-1:0] burst_cnt, burst_next;
    logic          miss_event;

    // Answer outranks hang-up and cadence expiry while alerting.
    always_comb begin
        state_next = state;
        cycle_next = cycle_cnt;
        burst_next = burst_cnt;
        miss_event = 1'b0;
        case (state)
            S_IDLE: begin
                if (incoming_call && !answer) begin
                    state_next = S_ON;
                    cycle_next = '0;
                    burst_next = '0;
                end
            end
            S_ON: begin
                if (answer) begin
                    state_next = S_ANSWERED;
                end else if (!incoming_call) begin
                    state_next = S_IDLE;
                    miss_event = 1'b1;
                end else if (cycle_cnt == CW'(ON_CYCLES - 1)) begin
                    state_next = S_OFF;
                    cycle_next = '0;
                    burst_next = burst_cnt + BW'(1);
                end else begin
                    cycle_next = cycle_cnt + CW'(1);
                end
            end
            S_OFF: begin
                if (answer) begin
                    state_next = S_ANSWERED;
                end else if (!incoming_call) begin
                    state_next = S_IDLE;
                    miss_event = 1'b1;
                end else if (cycle_cnt == CW'(OFF_CYCLES - 1)) begin
                    cycle_next = '0;
                    if (burst_cnt == BW'(MAX_BURSTS)) begin
                        state_next = S_DONE;
                        miss_event = 1'b1;
                    end else begin
                        state_next = S_ON;
                    end
                end else begin
                    cycle_next = cycle_cnt + CW'(1);
                end
            end
            S_DONE, S_ANSWERED: begin
                if (!incoming_call) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cycle_next = '0;
                burst_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            cycle_cnt <= cycle_next;
            burst_cnt <= burst_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= M_NORMAL;
        end else if (mode_btn) begin
            case (mode)
                M_NORMAL:  mode <= M_VIBRATE;
                M_VIBRATE: mode <= M_SILENT;
                default:   mode <= M_NORMAL;
            endcase
        end
    end

    // A miss landing together with a clear leaves exactly that one miss recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            missed_call  <= 1'b0;
            missed_count <= 4'd0;
        end else if (miss_event) begin
            missed_call <= 1'b1;
            if (clr_missed) begin
                missed_count <= 4'd1;
            end else if (missed_count != 4'd15) begin
                missed_count <= missed_count + 4'd1;
            end
        end else if (clr_missed) begin
            missed_call  <= 1'b0;
            missed_count <= 4'd0;
        end
    end

    assign ring         = (state == S_ON) && (mode != M_SILENT);
    assign vibrate_mode = (mode == M_VIBRATE);

endmodule
